// File: rtl/riscvsys_evcnt.sv
// riscvsys_evcnt - event counter bank with a one-cycle-latency read port.
//
// One counter per event class, plus a retire counter at index N_EVENTS.
// Each counter has a sticky overflow flag. A request/acknowledge read port
// returns the counter value, the overflow flag and an address-range error
// one cycle after each request.
//
// Optional build macro:
//   EVCNT_SATURATE_EN - counters saturate at all-ones instead of wrapping.
//
// Ports:
//   i_clk      clock, rising edge
//   i_rstn     asynchronous active-low reset
//   i_ev       per-class event pulses (any number may be high together)
//   i_retire   instruction-retire strobe (drives the retire counter)
//   i_enable   count enable; low freezes every counter
//   i_clear    synchronous clear of all counters and overflow flags
//   i_rd_req   read request
//   i_rd_addr  0..N_EVENTS-1 event counter, N_EVENTS retire counter
//   o_rd_ack   read response valid
//   o_rd_data  counter value as of the request cycle
//   o_rd_ovf   overflow flag of the addressed counter
//   o_rd_err   address out of range
//   o_any_ovf  registered OR of all overflow flags
module riscvsys_evcnt #(
  parameter int N_EVENTS = 49,
  parameter int CNT_W    = 32,
  parameter int ADDR_W   = 6
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic [N_EVENTS-1:0] i_ev,
  input  logic                i_retire,
  input  logic                i_enable,
  input  logic                i_clear,
  input  logic                i_rd_req,
  input  logic [ADDR_W-1:0]   i_rd_addr,
  output logic                o_rd_ack,
  output logic [CNT_W-1:0]    o_rd_data,
  output logic                o_rd_ovf,
  output logic                o_rd_err,
  output logic                o_any_ovf
);

  localparam int N_CNT = N_EVENTS + 1;

  logic [CNT_W-1:0] cnt_r [N_CNT];
  logic [N_CNT-1:0] ovf_r;
  logic [N_CNT-1:0] hit_s;

  logic [CNT_W-1:0] sel_data_s;
  logic             sel_ovf_s;
  logic             sel_err_s;

  logic             rd_ack_r;
  logic [CNT_W-1:0] rd_data_r;
  logic             rd_ovf_r;
  logic             rd_err_r;
  logic             any_ovf_r;

  // Retire counter sits at the top index so the read address maps directly.
  assign hit_s = {i_retire, i_ev};

  // Counter bank: clear beats events; increments at all-ones raise the sticky flag.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int k = 0; k < N_CNT; k++) begin
        cnt_r[k] <= '0;
      end
      ovf_r <= '0;
    end else if (i_clear) begin
      for (int k = 0; k < N_CNT; k++) begin
        cnt_r[k] <= '0;
      end
      ovf_r <= '0;
    end else if (i_enable) begin
      for (int k = 0; k < N_CNT; k++) begin
        if (hit_s[k]) begin
          if (&cnt_r[k]) begin
            ovf_r[k] <= 1'b1;
`ifdef EVCNT_SATURATE_EN
            cnt_r[k] <= cnt_r[k];
`else
            cnt_r[k] <= '0;
`endif
          end else begin
            cnt_r[k] <= cnt_r[k] + CNT_W'(1);
          end
        end
      end
    end
  end

  // Read mux: one-hot OR over the bank; no match means address out of range.
  always_comb begin
    sel_data_s = '0;
    sel_ovf_s  = 1'b0;
    sel_err_s  = 1'b1;
    for (int k = 0; k < N_CNT; k++) begin
      sel_data_s = sel_data_s | ({CNT_W{i_rd_addr == ADDR_W'(k)}} & cnt_r[k]);
      sel_ovf_s  = sel_ovf_s | ((i_rd_addr == ADDR_W'(k)) & ovf_r[k]);
      sel_err_s  = sel_err_s & (i_rd_addr != ADDR_W'(k));
    end
  end

  // Read response and overflow summary registers; data/ovf hold when idle.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rd_ack_r  <= 1'b0;
      rd_data_r <= '0;
      rd_ovf_r  <= 1'b0;
      rd_err_r  <= 1'b0;
      any_ovf_r <= 1'b0;
    end else begin
      rd_ack_r  <= i_rd_req;
      any_ovf_r <= |ovf_r;
      if (i_rd_req) begin
        rd_data_r <= sel_data_s;
        rd_ovf_r  <= sel_ovf_s;
        rd_err_r  <= sel_err_s;
      end else begin
        rd_err_r  <= 1'b0;
      end
    end
  end

  assign o_rd_ack  = rd_ack_r;
  assign o_rd_data = rd_data_r;
  assign o_rd_ovf  = rd_ovf_r;
  assign o_rd_err  = rd_err_r;
  assign o_any_ovf = any_ovf_r;

endmodule
